// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the RISC-V fetch/data memory arbiter.
package riscv_mem_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned LAT_CNT_W    = 3;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive fetch denials; force_o makes fetch win the
// next arbitration once the count reaches STARVE_MAX.
module mem_arb_starve_ctr
  import riscv_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic deny_i,
  input  logic clear_i,
  output logic force_o
);

  localparam logic [STARVE_CNT_W-1:0] SAT = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (deny_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q == SAT);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and data
// ports; data wins unless the fetch starvation guard (STARVE_GUARD_EN) forces fetch.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic              DM_GNT,
  output logic              DM_RVALID,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

  arb_state_e           state_q, state_d;
  arb_owner_e           owner_q, owner_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic                 if_rvalid_q, if_rvalid_d;
  logic                 dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]    dm_rdata_q, dm_rdata_d;
  logic                 if_gnt, dm_gnt;
  logic                 force_if;

`ifdef STARVE_GUARD_EN
  logic if_denied, if_clear;

  assign if_denied = (state_q == IDLE) && !RST && IF_REQ && !if_gnt;
  assign if_clear  = if_gnt || !IF_REQ;

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk     (CLK),
    .rst     (RST),
    .deny_i  (if_denied),
    .clear_i (if_clear),
    .force_o (force_if)
  );
`else
  logic unused_starve_max;

  assign force_if          = 1'b0;
  assign unused_starve_max = (STARVE_MAX == 0);
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    MEM_EN      = 1'b0;
    MEM_WE      = 1'b0;
    MEM_ADDR    = '0;
    MEM_WDATA   = '0;
    case (state_q)
      IDLE: begin
        // Grants are suppressed while RST is high so nothing reaches memory.
        if (!RST) begin
          if (IF_REQ && (force_if || !DM_REQ)) begin
            if_gnt = 1'b1;
          end else if (DM_REQ) begin
            dm_gnt = 1'b1;
          end
        end
        if (if_gnt) begin
          MEM_EN    = 1'b1;
          MEM_ADDR  = IF_ADDR;
          owner_d   = OWN_IF;
          lat_cnt_d = LAT_LOAD;
          state_d   = WAIT;
        end else if (dm_gnt) begin
          MEM_EN    = 1'b1;
          MEM_WE    = DM_WE;
          MEM_ADDR  = DM_ADDR;
          MEM_WDATA = DM_WDATA;
          if (!DM_WE) begin
            owner_d   = OWN_DM;
            lat_cnt_d = LAT_LOAD;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == LAT_ONE) begin
          state_d = IDLE;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = MEM_RDATA;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = MEM_RDATA;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_cnt_q   <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign IF_GNT    = if_gnt;
  assign DM_GNT    = dm_gnt;
  assign IF_RVALID = if_rvalid_q;
  assign DM_RVALID = dm_rvalid_q;
  assign IF_RDATA  = if_rdata_q;
  assign DM_RDATA  = dm_rdata_q;
  assign BUSY      = (state_q == WAIT);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter at MEM_LAT 1 and 3: directed scenarios with literal
// expectations plus randomized traffic checked every cycle by a behavioural model.
module tb_riscv_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [2];
  logic          if_req [2], if_gnt [2], if_rvalid [2];
  logic [AW-1:0] if_addr [2];
  logic [DW-1:0] if_rdata [2];
  logic          dm_req [2], dm_we [2], dm_gnt [2], dm_rvalid [2];
  logic [AW-1:0] dm_addr [2];
  logic [DW-1:0] dm_wdata [2], dm_rdata [2];
  logic          mem_en [2], mem_we [2], busy [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2], mem_rdata [2];

  riscv_mem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .MEM_LAT (1), .STARVE_MAX (SMAX)
  ) u_dut_lat1 (
    .CLK (clk), .RST (rst[0]),
    .IF_REQ (if_req[0]), .IF_ADDR (if_addr[0]), .IF_GNT (if_gnt[0]),
    .IF_RVALID (if_rvalid[0]), .IF_RDATA (if_rdata[0]),
    .DM_REQ (dm_req[0]), .DM_WE (dm_we[0]), .DM_ADDR (dm_addr[0]),
    .DM_WDATA (dm_wdata[0]), .DM_GNT (dm_gnt[0]),
    .DM_RVALID (dm_rvalid[0]), .DM_RDATA (dm_rdata[0]),
    .MEM_EN (mem_en[0]), .MEM_WE (mem_we[0]), .MEM_ADDR (mem_addr[0]),
    .MEM_WDATA (mem_wdata[0]), .MEM_RDATA (mem_rdata[0]), .BUSY (busy[0])
  );

  riscv_mem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .MEM_LAT (3), .STARVE_MAX (SMAX)
  ) u_dut_lat3 (
    .CLK (clk), .RST (rst[1]),
    .IF_REQ (if_req[1]), .IF_ADDR (if_addr[1]), .IF_GNT (if_gnt[1]),
    .IF_RVALID (if_rvalid[1]), .IF_RDATA (if_rdata[1]),
    .DM_REQ (dm_req[1]), .DM_WE (dm_we[1]), .DM_ADDR (dm_addr[1]),
    .DM_WDATA (dm_wdata[1]), .DM_GNT (dm_gnt[1]),
    .DM_RVALID (dm_rvalid[1]), .DM_RDATA (dm_rdata[1]),
    .MEM_EN (mem_en[1]), .MEM_WE (mem_we[1]), .MEM_ADDR (mem_addr[1]),
    .MEM_WDATA (mem_wdata[1]), .MEM_RDATA (mem_rdata[1]), .BUSY (busy[1])
  );

  int unsigned n_checks, n_fail, cyc;

  // Memory contents and pending response, one set per instance.
  logic [DW-1:0] mem [2][256];
  logic          rsp_v [2];
  int unsigned   rsp_due [2];
  logic [DW-1:0] rsp_d [2];

  // Behavioural model state: cycles left until the read returns, who owns it,
  // what it will return, the expected registered outputs, and fetch denials.
  int unsigned   busy_left [2];
  logic          own_dm [2];
  logic [DW-1:0] pend [2];
  logic          ex_if_rv [2], ex_dm_rv [2];
  logic [DW-1:0] ex_if_rd [2], ex_dm_rd [2];
  int unsigned   starve [2];

  function automatic int unsigned lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned widx(input logic [AW-1:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [AW-1:0] raddr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'b0, w, 2'b00};
  endfunction

  task automatic check_b(input string name, input int i, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat%0d cyc %0d: got %b expected %b", name, lat_of(i), cyc, act, exp);
    end
  endtask

  task automatic check_w(input string name, input int i, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat%0d cyc %0d: got %h expected %h", name, lat_of(i), cyc, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    logic          eif, edm, idle, een, ewe;
    logic [AW-1:0] eaddr;
    idle = (busy_left[i] == 0);
    eif  = 1'b0;
    edm  = 1'b0;
    if (!rst[i] && idle) begin
      eif = if_req[i] && (!dm_req[i] || (GUARD && starve[i] >= SMAX));
      edm = dm_req[i] && !eif;
    end
    een   = eif || edm;
    ewe   = edm && dm_we[i];
    eaddr = eif ? if_addr[i] : (edm ? dm_addr[i] : '0);

    check_b("IF_GNT", i, if_gnt[i], eif);
    check_b("DM_GNT", i, dm_gnt[i], edm);
    check_b("MEM_EN", i, mem_en[i], een);
    check_b("MEM_WE", i, mem_we[i], ewe);
    check_w("MEM_ADDR", i, mem_addr[i], eaddr);
    if (ewe) check_w("MEM_WDATA", i, mem_wdata[i], dm_wdata[i]);
    else if (!een) check_w("MEM_WDATA", i, mem_wdata[i], '0);
    check_b("BUSY", i, busy[i], !idle);
    check_b("IF_RVALID", i, if_rvalid[i], ex_if_rv[i]);
    check_b("DM_RVALID", i, dm_rvalid[i], ex_dm_rv[i]);
    check_w("IF_RDATA", i, if_rdata[i], ex_if_rd[i]);
    check_w("DM_RDATA", i, dm_rdata[i], ex_dm_rd[i]);

    if (mem_en[i] && mem_we[i]) mem[i][widx(mem_addr[i])] = mem_wdata[i];
    if (mem_en[i] && !mem_we[i]) begin
      rsp_v[i]   = 1'b1;
      rsp_due[i] = cyc + lat_of(i);
      rsp_d[i]   = mem[i][widx(mem_addr[i])];
    end

    if (rst[i]) begin
      busy_left[i] = 0;
      ex_if_rv[i]  = 1'b0;
      ex_dm_rv[i]  = 1'b0;
      ex_if_rd[i]  = '0;
      ex_dm_rd[i]  = '0;
      starve[i]    = 0;
    end else begin
      ex_if_rv[i] = 1'b0;
      ex_dm_rv[i] = 1'b0;
      if (!idle) begin
        busy_left[i]--;
        if (busy_left[i] == 0) begin
          if (own_dm[i]) begin
            ex_dm_rv[i] = 1'b1;
            ex_dm_rd[i] = pend[i];
          end else begin
            ex_if_rv[i] = 1'b1;
            ex_if_rd[i] = pend[i];
          end
        end
      end else if (eif || (edm && !dm_we[i])) begin
        busy_left[i] = lat_of(i);
        own_dm[i]    = edm;
        pend[i]      = mem[i][widx(eaddr)];
      end
      if (!if_req[i] || eif) starve[i] = 0;
      else if (idle && starve[i] < SMAX) starve[i]++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Memory read port: valid data only in the return cycle, noise otherwise.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < 2; i++)
      mem_rdata[i] = (rsp_v[i] && rsp_due[i] == cyc) ? rsp_d[i] : $urandom;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input int i, input logic ig, input logic dg,
                              input int unsigned dm_pct);
    rst[i] = ($urandom_range(0, 249) == 0);
    if (ig) if_req[i] = 1'b0;
    if (dg) begin
      dm_req[i] = 1'b0;
      dm_we[i]  = 1'b0;
    end
    if (!if_req[i] && $urandom_range(0, 99) < 60) begin
      if_req[i]  = 1'b1;
      if_addr[i] = raddr();
    end
    if (!dm_req[i] && $urandom_range(0, 99) < dm_pct) begin
      dm_req[i]   = 1'b1;
      dm_we[i]    = 1'($urandom_range(0, 1));
      dm_addr[i]  = raddr();
      dm_wdata[i] = $urandom;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ig [2], dg [2];
    int unsigned first_if;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      if_req[i] = 1'b0; if_addr[i] = '0;
      dm_req[i] = 1'b0; dm_we[i] = 1'b0; dm_addr[i] = '0; dm_wdata[i] = '0;
      mem_rdata[i] = '0;
      rsp_v[i] = 1'b0; rsp_due[i] = 0; rsp_d[i] = '0;
      busy_left[i] = 0; own_dm[i] = 1'b0; pend[i] = '0; starve[i] = 0;
      ex_if_rv[i] = 1'b0; ex_dm_rv[i] = 1'b0; ex_if_rd[i] = '0; ex_dm_rd[i] = '0;
      for (int k = 0; k < 256; k++) mem[i][k] = {16'hC0DE, 8'h00, 8'(k)};
    end
    mem[0][4] = 32'h0050_0093;

    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_b("rst IF_GNT", i, if_gnt[i], 1'b0);
      check_b("rst MEM_EN", i, mem_en[i], 1'b0);
      check_b("rst BUSY", i, busy[i], 1'b0);
      check_b("rst IF_RVALID", i, if_rvalid[i], 1'b0);
      check_w("rst IF_RDATA", i, if_rdata[i], 32'h0);
      check_w("rst DM_RDATA", i, dm_rdata[i], 32'h0);
      check_w("rst MEM_ADDR", i, mem_addr[i], 32'h0);
    end

    // Single fetch, MEM_LAT=1
    step(); if_req[0] = 1'b1; if_addr[0] = 32'h10;
    @(negedge clk);
    check_b("t1 IF_GNT", 0, if_gnt[0], 1'b1);
    check_b("t1 MEM_EN", 0, mem_en[0], 1'b1);
    check_w("t1 MEM_ADDR", 0, mem_addr[0], 32'h10);
    step(); if_req[0] = 1'b0;
    @(negedge clk);
    check_b("t1 BUSY", 0, busy[0], 1'b1);
    step();
    @(negedge clk);
    check_b("t1 IF_RVALID", 0, if_rvalid[0], 1'b1);
    check_w("t1 IF_RDATA", 0, if_rdata[0], 32'h0050_0093);
    check_b("t1 DM_RVALID", 0, dm_rvalid[0], 1'b0);

    // Simultaneous fetch and load: data first, fetch two cycles later
    step();
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h100;
    @(negedge clk);
    check_b("t2 DM_GNT", 0, dm_gnt[0], 1'b1);
    check_b("t2 IF_GNT", 0, if_gnt[0], 1'b0);
    step(); dm_req[0] = 1'b0;
    @(negedge clk);
    check_b("t2 IF_GNT wait", 0, if_gnt[0], 1'b0);
    step();
    @(negedge clk);
    check_b("t2 DM_RVALID", 0, dm_rvalid[0], 1'b1);
    check_b("t2 IF_RVALID", 0, if_rvalid[0], 1'b0);
    check_w("t2 DM_RDATA", 0, dm_rdata[0], 32'hC0DE_0040);
    check_b("t2 IF_GNT late", 0, if_gnt[0], 1'b1);
    step(); if_req[0] = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    check_b("t2 IF_RVALID late", 0, if_rvalid[0], 1'b1);
    check_w("t2 IF_RDATA", 0, if_rdata[0], 32'hC0DE_0008);

    // Back-to-back stores, then read one back
    for (int k = 0; k < 3; k++) begin
      step();
      dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h40; dm_wdata[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      check_b("t3 MEM_WE", 0, mem_we[0], 1'b1);
      check_b("t3 DM_GNT", 0, dm_gnt[0], 1'b1);
      check_b("t3 BUSY", 0, busy[0], 1'b0);
      check_b("t3 DM_RVALID", 0, dm_rvalid[0], 1'b0);
    end
    step(); dm_we[0] = 1'b0;
    @(negedge clk);
    check_b("t3 load DM_GNT", 0, dm_gnt[0], 1'b1);
    step(); dm_req[0] = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    check_w("t3 DM_RDATA", 0, dm_rdata[0], 32'hDEAD_BEEF);

    // Continuous stores with fetch held
    first_if = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h44; dm_wdata[0] = 32'(k);
      if_req[0] = (first_if == 0); if_addr[0] = 32'h30;
      @(negedge clk);
      if (if_gnt[0] && first_if == 0) first_if = k;
    end
    check_w("t4 first IF_GNT cycle", 0, 32'(first_if), GUARD ? 32'd5 : 32'd0);
    step(); dm_req[0] = 1'b0; dm_we[0] = 1'b0; if_req[0] = 1'b0;
    repeat (3) step();

    // Reset during an outstanding load, MEM_LAT=3
    @(negedge clk);
    step(); dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h80;
    @(negedge clk);
    check_b("t5 DM_GNT", 1, dm_gnt[1], 1'b1);
    step(); dm_req[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    step(); rst[1] = 1'b0; dm_req[1] = 1'b1; dm_addr[1] = 32'h84;
    @(negedge clk);
    check_b("t5 BUSY after rst", 1, busy[1], 1'b0);
    check_b("t5 DM_GNT after rst", 1, dm_gnt[1], 1'b1);
    step(); dm_req[1] = 1'b0;
    @(negedge clk);
    check_b("t5 DM_RVALID quiet", 1, dm_rvalid[1], 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      check_b("t5 DM_RVALID quiet", 1, dm_rvalid[1], 1'b0);
    end
    step();
    @(negedge clk);
    check_b("t5 DM_RVALID", 1, dm_rvalid[1], 1'b1);
    check_w("t5 DM_RDATA", 1, dm_rdata[1], 32'hC0DE_0021);

    // Randomized traffic, light then heavy data load
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ig[i] = if_gnt[i];
        dg[i] = dm_gnt[i];
      end
      step();
      for (int i = 0; i < 2; i++) drive_random(i, ig[i], dg[i], (c < 2000) ? 50 : 90);
    end

    step();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; if_req[i] = 1'b0; dm_req[i] = 1'b0; dm_we[i] = 1'b0;
    end
    repeat (6) step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one single-port synchronous memory between the CPU's instruction-fetch port and data port. Sits between the RISC-V core and the unified memory model in the testbench/system. Grants one transaction at a time, sequences the fixed-latency read return, and routes read data back to the owning requester. Data accesses have priority, with an optional starvation guard for fetch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from MEM_EN to valid MEM_RDATA (legal range 1..7)
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win (legal range 1..15)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- IF_REQ  in  1  fetch request; held until IF_GNT
- IF_ADDR  in  ADDR_W  fetch address; stable while IF_REQ
- IF_GNT  out  1  fetch accepted this cycle
- IF_RVALID  out  1  one-cycle pulse, IF_RDATA valid
- IF_RDATA  out  DATA_W  fetched instruction
- DM_REQ  in  1  data request; held until DM_GNT
- DM_WE  in  1  1 = store, 0 = load
- DM_ADDR  in  ADDR_W  data address
- DM_WDATA  in  DATA_W  store data
- DM_GNT  out  1  data access accepted this cycle
- DM_RVALID  out  1  one-cycle pulse, DM_RDATA valid (loads only)
- DM_RDATA  out  DATA_W  load data
- MEM_EN  out  1  memory access strobe
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory read data
- BUSY  out  1  read outstanding

## Operation
- FSM states: IDLE, WAIT. Reset -> IDLE.
- IDLE: arbitrate combinationally. Winner gets GNT in the same cycle; MEM_EN=1, MEM_ADDR/MEM_WE/MEM_WDATA from winner. No request -> MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
- Priority: DM over IF. Starvation guard (see Configuration) may override.
- Store granted: no read return, stay IDLE; another grant is possible next cycle.
- Load/fetch granted: latch owner, load latency counter with MEM_LAT, go WAIT. BUSY=1 in WAIT.
- WAIT: no grants, MEM_EN=0. Counter decrements each cycle. In the cycle MEM_RDATA is valid (MEM_LAT cycles after grant), register it into the owner's RDATA and go IDLE. Owner's RVALID is high the following cycle.
- RDATA holds its last value until the next return. Only the owner's RVALID pulses.
- A request arriving during WAIT is held by the requester and arbitrated on return to IDLE.
- Reset mid-WAIT: outstanding read dropped, no RVALID, FSM -> IDLE.

## Timing
- Reset values: all GNT/RVALID/MEM_EN/MEM_WE/BUSY = 0; RDATA, MEM_ADDR, MEM_WDATA = 0.
- Read grant at cycle t: MEM_RDATA sampled at t+MEM_LAT; RVALID/RDATA at t+MEM_LAT+1; next grant possible at t+MEM_LAT+1. Read throughput is 1 per MEM_LAT+1 cycles.
- Store: grant and memory write at cycle t; next grant at t+1.
- GNT is combinational from REQ in IDLE. RVALID, RDATA and BUSY are registered.
- Simultaneous IF_REQ and DM_REQ in IDLE: DM wins unless the starvation guard forces IF.

## Configuration
- STARVE_GUARD_EN defined:
  - Counter increments on each IDLE cycle where IF_REQ=1 and IF loses. It saturates at STARVE_MAX.
  - When the count equals STARVE_MAX, IF wins the next arbitration.
  - Counter clears on IF_GNT, on IF_REQ=0, and on RST.
- Undefined: strict DM priority; IF may starve indefinitely.

## Structure
- Package riscv_mem_pkg: FSM state typedef (IDLE, WAIT), owner typedef (OWN_IF, OWN_DM), default width constants.
- Sub-module mem_arb_starve_ctr: saturating denial counter with force output. Instantiated only under STARVE_GUARD_EN.

## Test plan
- Reset then idle, with MEM_LAT=1: IF_REQ, IF_ADDR=0x10 at t. Expected: IF_GNT and MEM_EN at t, MEM_ADDR=0x10; MEM_RDATA=0x00500093 at t+1; IF_RVALID=1 and IF_RDATA=0x00500093 at t+2.
- Simultaneous IF_REQ with DM load to 0x100. Expected: DM_GNT first; IF_GNT at t+2 (MEM_LAT=1); DM_RVALID only, IF_RVALID=0 on that return.
- DM store 0xDEADBEEF to 0x40 every cycle for 3 cycles. Expected: MEM_WE=1 on 3 consecutive cycles, no RVALID, BUSY=0.
- With STARVE_GUARD_EN and STARVE_MAX=4: continuous DM stores plus IF_REQ held. Expected: IF_GNT on the 5th arbitration cycle; without the macro, IF_GNT never asserts.
- RST asserted at t+1 after a load grant at t, with MEM_LAT=3. Expected: no DM_RVALID afterwards, BUSY=0 at t+2, new request granted in the first cycle after RST is released.
